// File: rtl/redirect_sched.sv
// -----------------------------------------------------------------------------
// redirect_sched
//
// Arbitrates per-target-port redirect requests and sequences exactly one
// route override at a time onto the crossbar config port:
//   program (enable=1, valid/ready) -> hold for a bounded window -> remove
//   (enable=0, valid/ready).
// Round-robin fairness across target ports. A port that has been acknowledged
// is not granted again until it deasserts its request.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid_i[p]       level redirect request of target port p
//   req_source_i/target  packed per-port source/target initiator indices
//   req_ack_o[p]         one-cycle pulse when port p is granted or dropped
//   cfg_valid_o/ready_i  config command handshake towards the crossbar
//   cfg_enable_o         1 = apply override, 0 = remove override
//   cfg_port/source/target_o  command payload (stable while valid & !ready)
//   override_active_o    high during the hold window of an applied override
//   active_port_o        port owning the current (or last) grant
//   busy_o               sequencer is not idle
//   drop_cnt_o           saturating count of requests dropped as src == tgt
// -----------------------------------------------------------------------------
module redirect_sched #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_INIT  = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8,
  parameter int PORT_W      = $clog2(N_TARG_PORT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_TARG_PORT-1:0]            req_valid_i,
  input  logic [N_TARG_PORT*LOG_N_INIT-1:0] req_source_i,
  input  logic [N_TARG_PORT*LOG_N_INIT-1:0] req_target_i,
  output logic [N_TARG_PORT-1:0]            req_ack_o,
  output logic                              cfg_valid_o,
  input  logic                              cfg_ready_i,
  output logic                              cfg_enable_o,
  output logic [PORT_W-1:0]                 cfg_port_o,
  output logic [LOG_N_INIT-1:0]             cfg_source_o,
  output logic [LOG_N_INIT-1:0]             cfg_target_o,
  output logic                              override_active_o,
  output logic [PORT_W-1:0]                 active_port_o,
  output logic                              busy_o,
  output logic [7:0]                        drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, PROG, HOLD, UNPROG} state_t;

  state_t                   state;
  logic [PORT_W-1:0]        rr_ptr;
  logic [N_TARG_PORT-1:0]   served;
  logic [PORT_W-1:0]        port_q;
  logic [LOG_N_INIT-1:0]    src_q;
  logic [LOG_N_INIT-1:0]    tgt_q;
  logic [CNT_W-1:0]         hold_cnt;
  logic                     cfg_valid_q;
  logic                     cfg_enable_q;
  logic                     override_q;
  logic                     busy_q;
  logic [7:0]               drop_q;

  logic [LOG_N_INIT-1:0]    src_arr [N_TARG_PORT];
  logic [LOG_N_INIT-1:0]    tgt_arr [N_TARG_PORT];
  logic [N_TARG_PORT-1:0]   eligible;
  logic                     grant_found;
  logic [PORT_W-1:0]        grant_port;
  logic [LOG_N_INIT-1:0]    grant_src;
  logic [LOG_N_INIT-1:0]    grant_tgt;
  logic                     grant_degen;
  logic                     grant_now;

  // (base + off) mod N_TARG_PORT, valid for base < N and off < N.
  function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] base,
                                                 input int off);
    logic [PORT_W:0] s;
    s = {1'b0, base} + (PORT_W+1)'(off);
    if (s >= (PORT_W+1)'(N_TARG_PORT))
      s = s - (PORT_W+1)'(N_TARG_PORT);
    return s[PORT_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_TARG_PORT; i++) begin
      src_arr[i] = req_source_i[i*LOG_N_INIT +: LOG_N_INIT];
      tgt_arr[i] = req_target_i[i*LOG_N_INIT +: LOG_N_INIT];
    end
  end

  // A port stays ineligible after its ack until it drops its request.
  assign eligible = req_valid_i & ~served;

  // Round-robin search: walk from the lowest priority candidate to the
  // highest so the last hit (closest to rr_ptr) wins.
  always_comb begin
    grant_found = 1'b0;
    grant_port  = '0;
    for (int k = N_TARG_PORT - 1; k >= 0; k--) begin
      if (eligible[wrap_add(rr_ptr, k)]) begin
        grant_found = 1'b1;
        grant_port  = wrap_add(rr_ptr, k);
      end
    end
  end

  assign grant_src   = src_arr[grant_port];
  assign grant_tgt   = tgt_arr[grant_port];
  assign grant_degen = (grant_src == grant_tgt);

  // The ack must pulse in the decision cycle, so it is a decode of the
  // registered state and the live requests; it is masked during reset.
  assign grant_now = rst_n && (state == IDLE) && grant_found;
  assign req_ack_o = grant_now ? (N_TARG_PORT'(1) << grant_port) : '0;

  // ---- stage: sequencer state and registered command outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      served       <= '0;
      port_q       <= '0;
      src_q        <= '0;
      tgt_q        <= '0;
      hold_cnt     <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_enable_q <= 1'b0;
      override_q   <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      served <= req_valid_i & (served | req_ack_o);

      unique case (state)
        IDLE: begin
          if (grant_found) begin
            port_q <= grant_port;
            src_q  <= grant_src;
            tgt_q  <= grant_tgt;
            if (grant_degen) begin
              // Redirecting a source onto itself is meaningless: acknowledge
              // and count it, but never touch the crossbar.
              drop_q <= sat_inc8(drop_q);
              rr_ptr <= wrap_add(grant_port, 1);
            end else begin
              state        <= PROG;
              cfg_valid_q  <= 1'b1;
              cfg_enable_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end

        PROG: begin
          if (cfg_ready_i) begin
            state       <= HOLD;
            cfg_valid_q <= 1'b0;
            hold_cnt    <= CNT_W'(HOLD_CYCLES - 1);
            override_q  <= 1'b1;
          end
        end

        HOLD: begin
          hold_cnt <= hold_cnt - CNT_W'(1);
          // Leave early if the owner withdraws its request.
          if (hold_cnt == '0 || !req_valid_i[port_q]) begin
            state        <= UNPROG;
            cfg_valid_q  <= 1'b1;
            cfg_enable_q <= 1'b0;
            override_q   <= 1'b0;
          end
        end

        UNPROG: begin
          if (cfg_ready_i) begin
            state       <= IDLE;
            cfg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr      <= wrap_add(port_q, 1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cfg_valid_o       = cfg_valid_q;
  assign cfg_enable_o      = cfg_enable_q;
  assign cfg_port_o        = port_q;
  assign cfg_source_o      = src_q;
  assign cfg_target_o      = tgt_q;
  assign override_active_o = override_q;
  assign active_port_o     = port_q;
  assign busy_o            = busy_q;
  assign drop_cnt_o        = drop_q;

endmodule

// File: doc/redirect_sched.md
Name: redirect_sched

Overview:
Arbitrates the per-target-port redirect requests produced by the redirect detectors (valid/source/target per port) and sequences them onto the single crossbar route-override config port. Exactly one redirect is applied at a time. The sequence is: program the override with a valid/ready handshake, hold it for a bounded window, then remove it. Round-robin fairness applies across target ports. Sits between the redirect detectors and the AXI crossbar routing config.

Parameters:
N_TARG_PORT, 7, number of target ports / requesters
LOG_N_INIT, 2, width of source/target initiator index
HOLD_CYCLES, 16, max cycles an override stays applied; legal range is 1 to 2^CNT_W-1
CNT_W, 8, hold counter width
PORT_W, $clog2(N_TARG_PORT), width of port index

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid_i  in  N_TARG_PORT  level redirect request per port
req_source_i  in  N_TARG_PORT*LOG_N_INIT  requested source initiator per port
req_target_i  in  N_TARG_PORT*LOG_N_INIT  requested target initiator per port
req_ack_o  out  N_TARG_PORT  one-cycle pulse on the granted (or dropped) port
cfg_valid_o  out  1  config command valid
cfg_ready_i  in  1  crossbar accepts config command
cfg_enable_o  out  1  1 = apply override, 0 = remove override
cfg_port_o  out  PORT_W  target port of command
cfg_source_o  out  LOG_N_INIT  source of command
cfg_target_o  out  LOG_N_INIT  target of command
override_active_o  out  1  override currently applied
active_port_o  out  PORT_W  port owning current/last grant
busy_o  out  1  FSM not in IDLE
drop_cnt_o  out  8  saturating count of rejected degenerate requests

Behaviour:
- Reset (sync, rst_n=0 at posedge):
  - state=IDLE; rr_ptr=0; served=0.
  - All outputs 0: req_ack_o, cfg_*, override_active_o, active_port_o, busy_o, drop_cnt_o.
  - Reset mid-operation aborts immediately; no remove command is issued (crossbar shares the reset).
- Eligibility: port i is eligible when req_valid_i[i]=1 and served[i]=0.
  - served[i] sets on ack of port i.
  - served[i] clears in any cycle where req_valid_i[i]=0.
  - A port must deassert before it can be granted again.
- States: IDLE, PROG, HOLD, UNPROG.
- IDLE: if any port is eligible, pick the first eligible port searching from rr_ptr upward, wrapping modulo N_TARG_PORT. In the same cycle:
  - Pulse req_ack_o[i].
  - Latch port, source and target.
  - If source==target (degenerate): drop the request, drop_cnt_o++ (saturates at 255), stay IDLE, set rr_ptr=i+1 mod N.
  - Otherwise go to PROG next cycle.
- PROG:
  - cfg_valid_o=1, cfg_enable_o=1, payload = latched values.
  - Payload stays stable while cfg_ready_i=0.
  - On cfg_valid_o & cfg_ready_i: go to HOLD, load hold_cnt=HOLD_CYCLES-1, override_active_o=1 from the next cycle.
- HOLD:
  - cfg_valid_o=0. hold_cnt decrements each cycle.
  - Go to UNPROG when hold_cnt==0 or req_valid_i[active]=0, whichever comes first.
  - Override is applied for at most HOLD_CYCLES cycles.
- UNPROG:
  - cfg_valid_o=1, cfg_enable_o=0, same port/source/target payload, held until cfg_ready_i.
  - On handshake: go to IDLE, override_active_o=0 next cycle, rr_ptr=active+1 mod N.
- Request-side changes while not in IDLE:
  - New or changed req_* on any port are ignored; the latched payload does not change.
  - Requests wait. The active port's served bit stays set unless it deasserts.
- Latency: grant to cfg_valid_o is 1 cycle. Minimum full sequence (ready always 1, HOLD_CYCLES=H) is 1 IDLE + 1 PROG + H HOLD + 1 UNPROG = H+3 cycles.
- Simultaneous events:
  - Deassert on the same cycle as the PROG handshake: HOLD is entered, then exits after 1 cycle.
  - Request arriving during UNPROG handshake: evaluated in the next IDLE cycle.
- busy_o = (state != IDLE).
- active_port_o holds its last value in IDLE.

Test Plan:
- Single request, port 3, src=1, tgt=2, ready=1, H=16 -> ack[3] at cycle 0; cfg_valid enable=1 at cycle 1; override_active cycles 2..17; remove command at cycle 18; IDLE at cycle 19.
- Ports 0 and 5 request together, held high -> port 0 granted first. After release port 5 is granted. Port 0 is not re-granted until it deasserts and reasserts.
- cfg_ready_i low for 5 cycles in PROG and in UNPROG -> cfg_valid_o held with stable payload for 6 cycles each; no extra acks.
- Port 2 deasserts 4 cycles into HOLD -> UNPROG the next cycle; override lasts 4 cycles, not 16.
- Port 1 requests src=tgt=3 -> ack pulse, no cfg_valid, drop_cnt_o=1, rr_ptr=2. 300 such requests -> drop_cnt_o saturates at 255.
- rst_n low mid-HOLD -> next cycle all outputs 0, state IDLE, served cleared. Still-asserted requests are re-granted starting from port 0.
